int_to_float_pipe: RTL and testbench
====================================

INT_TO_FLOAT_PIPE -- requirements
Module: int_to_float_pipe

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 8, meaning the input integer width, legal range 2..32.
REQ-002 The block SHALL expose parameter SIGNED, default 0, meaning 0 = unsigned input and 1 = two's-complement input.
REQ-003 Port clk SHALL be an input, 1 bit: the single clock; all state is rising-edge.
REQ-004 Port rst_n SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-005 Port in_valid SHALL be an input, 1 bit: in_data is valid.
REQ-006 Port in_ready SHALL be an output, 1 bit: the block accepts in_data this cycle.
REQ-007 Port in_data SHALL be an input, WIDTH bits: the integer operand.
REQ-008 Port out_valid SHALL be an output, 1 bit: out_data and out_inexact are valid.
REQ-009 Port out_ready SHALL be an input, 1 bit: the downstream consumer accepts the result.
REQ-010 Port out_data SHALL be an output, 32 bits: the IEEE-754 single-precision result.
REQ-011 Port out_inexact SHALL be an output, 1 bit: the result was rounded (nonzero bits were discarded).

Function
REQ-012 A transfer SHALL occur on a clock edge where valid and ready are both 1; this rule applies on both ports.
REQ-013 The pipeline SHALL be 3 register stages: S1 holds sign and magnitude; S2 holds leading-one detect and normalize shift; S3 holds round and pack.
REQ-014 Latency SHALL be exactly 3 cycles from input transfer to out_valid=1 when out_ready is held 1.
REQ-015 Throughput SHALL be 1 result per cycle while out_ready=1.
REQ-016 Each stage SHALL advance when its successor is empty or advancing, so that no bubble is forced while the pipe is full.
REQ-017 in_ready SHALL be the combinational function (S1 empty OR S1 advancing), with no combinational path from in_valid to in_ready.
REQ-018 While out_valid=1 and out_ready=0, out_data and out_inexact SHALL remain stable, and no result SHALL be dropped or duplicated.
REQ-019 Results SHALL leave the block in input order.
REQ-020 When SIGNED=1 and in_data[WIDTH-1]=1, the sign bit SHALL be 1 and the magnitude SHALL be the two's-complement negation, computed WIDTH+1 bits wide so that -2^(WIDTH-1) is exact.
REQ-021 A zero input SHALL produce 0x00000000 (+0.0) with out_inexact=0.
REQ-022 For a nonzero input, the exponent SHALL be p+127, where p is the index of the leading one.
REQ-023 For a nonzero input, the mantissa SHALL be the 23 bits below the leading one, left-aligned.
REQ-024 When p>23, rounding SHALL be round-to-nearest-even on the discarded bits (guard bit plus OR of all lower bits), and out_inexact SHALL be 1 whenever any discarded bit is 1.
REQ-025 A rounding carry out of the mantissa SHALL zero the mantissa and increment the exponent; overflow is impossible because WIDTH<=32.
REQ-026 For WIDTH<=24, out_inexact SHALL be tied to 0 and the rounding logic SHALL be pruned.

Reset
REQ-027 On rst_n=0, all stage-valid flags SHALL clear immediately (asynchronously).
REQ-028 During reset, out_valid SHALL be 0, out_data SHALL be 0x00000000, out_inexact SHALL be 0, and in_ready SHALL be 0.
REQ-029 in_ready SHALL return to 1 on the first clk edge after rst_n deasserts.
REQ-030 Reset asserted mid-stream SHALL discard all in-flight operands, and no stale result SHALL appear after reset.

Structure
REQ-031 Package int_to_float_pkg SHALL hold FP32_EXP_BIAS=127, FP32_EXP_W=8, FP32_MANT_W=23, and the typedef fp32_t (a packed sign/exp/mant struct).
REQ-032 Leading-one detection SHALL be the sub-module int_to_float_lod (parameter WIDTH; outputs: index and a zero flag).
REQ-033 Elaboration SHALL fail if WIDTH<2 or WIDTH>32.

Verification
REQ-034 Bench (WIDTH=8, SIGNED=0): inputs 0, 1, 128, 255 -> outputs 0x00000000, 0x3F800000, 0x43000000, 0x437F0000, each 3 cycles after acceptance, with inexact=0.
REQ-035 Bench (WIDTH=8, SIGNED=1): inputs 0x80 and 0xFF -> outputs 0xC3000000 (-128.0) and 0xBF800000 (-1.0).
REQ-036 Bench (WIDTH=32, SIGNED=0): input 0x01000001 -> 0x4B800000 with inexact=1 (tie, rounds to even).
REQ-037 Bench (WIDTH=32, SIGNED=0): input 0x01000003 -> 0x4B800002 with inexact=1.
REQ-038 Bench (WIDTH=32, SIGNED=0): input 0xFFFFFFFF -> 0x4F800000 with inexact=1 (mantissa carry into exponent).
REQ-039 Bench: stream 1..6 back-to-back while out_ready=0 for 5 cycles -> in_ready falls after 3 accepted operands, out_data holds 0x3F800000, and after release 1.0..6.0 arrive in order with none lost.
REQ-040 Bench: assert rst_n=0 with 2 operands in flight, then release -> out_valid stays 0 until a new operand is accepted, and its result appears 3 cycles later.

Source files
------------

// File: rtl/int_to_float_pkg.sv
// Shared FP32 field widths, exponent bias and packed result type for the
// integer-to-float pipeline.
package int_to_float_pkg;
  localparam int FP32_EXP_BIAS = 127;
  localparam int FP32_EXP_W    = 8;
  localparam int FP32_MANT_W   = 23;

  typedef struct packed {
    logic                   sign;
    logic [FP32_EXP_W-1:0]  exp;
    logic [FP32_MANT_W-1:0] mant;
  } fp32_t;
endpackage

// File: rtl/int_to_float_lod.sv
// Leading-one detector: index of the most significant set bit, plus a flag
// for an all-zero operand (index is 0 in that case).
module int_to_float_lod #(
  parameter  int WIDTH = 8,
  localparam int IW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  output logic [IW-1:0]    index,
  output logic             zero
);

  always_comb begin
    index = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (data[i]) index = IW'(i);
    end
    zero = ~|data;
  end

endmodule

// File: rtl/int_to_float_pipe.sv
// Three-stage integer to IEEE-754 single-precision converter with
// valid/ready handshakes on both sides and round-to-nearest-even.
module int_to_float_pipe
  import int_to_float_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_inexact
);

  localparam int IW = $clog2(WIDTH);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("int_to_float_pipe: WIDTH must be in 2..32");
  end

  logic             run;
  logic             s1_v, s2_v, s3_v;
  logic             adv1, adv2, adv3;
  logic             s1_sign, s2_sign, s2_zero;
  logic [WIDTH-1:0] s1_mag, s2_frac;
  logic [IW-1:0]    s2_exp;
  fp32_t            s3_data;
  logic             s3_inex;

  // Each stage moves when the next one is empty or itself moving.
  assign adv3     = s3_v & out_ready;
  assign adv2     = s2_v & (~s3_v | adv3);
  assign adv1     = s1_v & (~s2_v | adv2);
  assign in_ready = run & (~s1_v | adv1);

  // Negation is done one bit wider so the most negative input is exact.
  logic             in_sign;
  logic [WIDTH:0]   in_ext;
  logic [WIDTH-1:0] in_mag;
  assign in_sign = (SIGNED != 0) & in_data[WIDTH-1];
  assign in_ext  = {in_data[WIDTH-1], in_data};
  assign in_mag  = in_sign ? WIDTH'(-in_ext) : in_data;

  logic [IW-1:0]    lod_idx;
  logic             lod_zero;
  logic [WIDTH-1:0] frac_c;

  int_to_float_lod #(.WIDTH(WIDTH)) u_lod (
    .data  (s1_mag),
    .index (lod_idx),
    .zero  (lod_zero)
  );

  // Shift the leading one out the top; what remains is the fraction, MSB-aligned.
  assign frac_c = s1_mag << (WIDTH - int'(lod_idx));

  logic [FP32_MANT_W-1:0] mant_c;
  logic                   carry_c;
  logic                   inex_c;

  if (WIDTH > 24) begin : g_round
    logic [FP32_MANT_W-1:0] mant_t;
    logic                   guard, sticky, rnd;
    assign mant_t = s2_frac[WIDTH-1 -: FP32_MANT_W];
    assign guard  = s2_frac[WIDTH-24];
    assign sticky = |s2_frac[WIDTH-25:0];
    assign rnd    = guard & (sticky | mant_t[0]);
    assign {carry_c, mant_c} = {1'b0, mant_t} + 24'(rnd);
    assign inex_c = guard | sticky;
  end else begin : g_exact
    assign mant_c  = FP32_MANT_W'({s2_frac, 23'b0} >> WIDTH);
    assign carry_c = 1'b0;
    assign inex_c  = 1'b0;
  end

  fp32_t pack_c;
  always_comb begin
    pack_c = '0;
    if (!s2_zero) begin
      pack_c.sign = s2_sign;
      pack_c.exp  = FP32_EXP_W'(FP32_EXP_BIAS) + FP32_EXP_W'(s2_exp) + FP32_EXP_W'(carry_c);
      pack_c.mant = mant_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run     <= 1'b0;
      s1_v    <= 1'b0;
      s2_v    <= 1'b0;
      s3_v    <= 1'b0;
      s1_sign <= 1'b0;
      s1_mag  <= '0;
      s2_sign <= 1'b0;
      s2_zero <= 1'b1;
      s2_exp  <= '0;
      s2_frac <= '0;
      s3_data <= '0;
      s3_inex <= 1'b0;
    end else begin
      run <= 1'b1;
      if (!s1_v || adv1) s1_v <= in_valid & run;
      if (!s2_v || adv2) s2_v <= s1_v;
      if (!s3_v || adv3) s3_v <= s2_v;
      if (in_valid && in_ready) begin
        s1_sign <= in_sign;
        s1_mag  <= in_mag;
      end
      if (adv1) begin
        s2_sign <= s1_sign;
        s2_zero <= lod_zero;
        s2_exp  <= lod_idx;
        s2_frac <= frac_c;
      end
      if (adv2) begin
        s3_data <= pack_c;
        s3_inex <= inex_c & ~s2_zero;
      end
    end
  end

  assign out_valid   = s3_v;
  assign out_data    = s3_data;
  assign out_inexact = s3_inex;

endmodule

// File: tb/tb_int_to_float_pipe.sv
// Bench for int_to_float_pipe: three instances (8-bit unsigned, 8-bit signed,
// 32-bit unsigned) driven in lockstep, with directed vectors and a random scoreboard.
module tb_int_to_float_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic [2:0]  ir, ov, ox;
  logic [31:0] od [3];

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  int_to_float_pipe #(.WIDTH(8), .SIGNED(0)) u_u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data[7:0]),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_inexact(ox[0]));
  int_to_float_pipe #(.WIDTH(8), .SIGNED(1)) u_s8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data[7:0]),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_inexact(ox[1]));
  int_to_float_pipe #(.WIDTH(32), .SIGNED(0)) u_u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .out_inexact(ox[2]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    ntot++;
    if (act === req) npass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // Reference: exact integer value -> float by plain arithmetic; returns {inexact, bits}.
  function automatic logic [32:0] model(input int sel, input logic [31:0] raw);
    longint v, m, q, rem, half;
    int     p, sh;
    logic   neg, inex;
    if (sel == 2)      v = longint'(raw);
    else if (sel == 1) v = longint'($signed(raw[7:0]));
    else               v = longint'(raw[7:0]);
    neg = (v < 0);
    m   = neg ? -v : v;
    if (m == 0) return 33'b0;
    p = 0;
    while ((m >> (p + 1)) != 0) p++;
    inex = 1'b0;
    if (p <= 23) begin
      q = m << (23 - p);
    end else begin
      sh   = p - 23;
      q    = m >> sh;
      rem  = m - (q << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      inex = (rem != 0);
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        p++;
      end
    end
    return {inex, neg, 8'(p + 127), 23'(q - (longint'(1) << 23))};
  endfunction

  // Scoreboard: expected results queued on each accept, popped on each output transfer.
  logic [32:0] sbq [3][$];
  logic [2:0]  hold_prev = '0;
  logic [32:0] prev_out [3];

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        sbq[i].delete();
        hold_prev[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (hold_prev[i])
          check($sformatf("hold%0d", i), {ov[i], ox[i], od[i]}, {1'b1, prev_out[i]});
        if (in_valid && ir[i]) sbq[i].push_back(model(i, in_data));
        if (ov[i] && out_ready) begin
          check($sformatf("sb_avail%0d", i), sbq[i].size() > 0, 1);
          if (sbq[i].size() > 0)
            check($sformatf("sb_data%0d", i), {ox[i], od[i]}, sbq[i].pop_front());
        end
        hold_prev[i] = ov[i] && !out_ready;
        prev_out[i]  = {ox[i], od[i]};
      end
    end
  end

  // One operand into an empty pipe; result must show exactly three edges after acceptance.
  task automatic single(input int sel, input logic [31:0] din, input logic [32:0] req);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = din;
    @(negedge clk); check("acc_ready", ir[sel], 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk); check($sformatf("lat1_%h", din), ov[sel], 0);
    @(negedge clk); check($sformatf("lat2_%h", din), ov[sel], 0);
    @(negedge clk); check($sformatf("lat3_%h", din), {ov[sel], ox[sel], od[sel]}, {1'b1, req});
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_ov%0d", tag, i), ov[i], 0);
      check($sformatf("%s_ir%0d", tag, i), ir[i], 0);
      check($sformatf("%s_od%0d", tag, i), {ox[i], od[i]}, 33'b0);
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, sbq[0].size() + sbq[1].size() + sbq[2].size(), 0);
  endtask

  typedef struct {
    int          sel;
    logic [31:0] din;
    logic [31:0] dout;
    logic        inex;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int   k, n;
    logic acc;
    logic [31:0] r;

    vecs[0]  = '{0, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[1]  = '{0, 32'h0000_0001, 32'h3F80_0000, 1'b0};
    vecs[2]  = '{0, 32'h0000_0080, 32'h4300_0000, 1'b0};
    vecs[3]  = '{0, 32'h0000_00FF, 32'h437F_0000, 1'b0};
    vecs[4]  = '{1, 32'h0000_0080, 32'hC300_0000, 1'b0};
    vecs[5]  = '{1, 32'h0000_00FF, 32'hBF80_0000, 1'b0};
    vecs[6]  = '{1, 32'h0000_007F, 32'h42FE_0000, 1'b0};
    vecs[7]  = '{2, 32'h0100_0001, 32'h4B80_0000, 1'b1};
    vecs[8]  = '{2, 32'h0100_0003, 32'h4B80_0002, 1'b1};
    vecs[9]  = '{2, 32'hFFFF_FFFF, 32'h4F80_0000, 1'b1};
    vecs[10] = '{2, 32'h00FF_FFFF, 32'h4B7F_FFFF, 1'b0};
    vecs[11] = '{2, 32'h0000_0000, 32'h0000_0000, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk); check("ready_before_edge", ir, 3'b000);
    @(posedge clk); #1 check("ready_after_edge", ir, 3'b111);

    foreach (vecs[j]) single(vecs[j].sel, vecs[j].din, {vecs[j].inex, vecs[j].dout});

    // Back-pressure: six operands offered while the output is stalled for 5 cycles.
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    k = 1;
    for (int c = 0; c < 5; c++) begin
      in_data = 32'(k);
      @(negedge clk);
      check($sformatf("bp_ready_c%0d", c), ir[0], c < 3);
      if (c >= 3) check($sformatf("bp_hold_c%0d", c), {ov[0], od[0]}, {1'b1, 32'h3F80_0000});
      acc = ir[0];
      @(posedge clk); #1;
      if (acc) k++;
    end
    out_ready = 1'b1;
    n = 0;
    while (k <= 6 && n < 50) begin
      in_data = 32'(k);
      @(negedge clk);
      acc = ir[0];
      @(posedge clk); #1;
      if (acc) k++;
      n++;
    end
    in_valid = 1'b0;
    check("bp_all_accepted", k, 7);
    drain("bp_drain");

    // Reset with two operands in flight.
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 32'd10;
    @(posedge clk); #1;
    in_data  = 32'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1 check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); check("midrst_ready_low", ir[0], 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); check($sformatf("midrst_nostale_c%0d", c), ov, 3'b000);
    end
    single(0, 32'd9, {1'b0, 32'h4110_0000});

    // Random traffic with random back-pressure, checked by the scoreboard.
    for (int c = 0; c < 800; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      r = $urandom;
      case ($urandom_range(0, 4))
        0: in_data = r;
        1: in_data = r & 32'hFF;
        2: in_data = (32'h1 << r[4:0]) + 32'(r[9:8]) - 32'd1;
        3: in_data = {r[31:24] | 8'h80, 24'h0} | 32'(r[7:0]);
        default: in_data = 32'hFFFF_FFFF - 32'(r[3:0]);
      endcase
    end
    drain("rand_drain");

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
